// File: rtl/hazard_tag_pipe.sv
// ---------------------------------------------------------------------------
// hazard_tag_pipe
//
// Purpose:
//   Produces the in-flight destination/branch tags that the hazard detector
//   compares against. The instruction entering decode is decoded (WISC-F24
//   ISA) into a small tag: does it write a register, which one, and is it a
//   control-transfer instruction. The tag then shifts through D -> X -> M -> W
//   in lock-step with the datapath pipeline registers, so the hazard detector
//   sees exactly what each datapath stage is holding.
//
// Ports:
//   clk            in   1       clock, all state updates on posedge
//   rst_n          in   1       asynchronous active-low reset
//   issue_inst     in   INST_W  instruction entering decode
//   issue_valid    in   1       issue_inst is a real instruction (0 = bubble)
//   stall          in   1       hazard stall; D receives a bubble
//   flush          in   1       taken branch/jump resolved in X; D gets a bubble
//   freeze         in   1       global hold; every stage keeps its contents
//   regWrtD/X/M/W  out  1       stage holds a register-writing instruction
//   wrtRegD/X/M/W  out  REG_W   destination register of that stage (0 if none)
//   branchInstD/X  out  1       stage holds J/JR/JAL/JALR/conditional branch
//   wr_pending_cnt out  3       number of stages D..W holding a writer (0..4)
// ---------------------------------------------------------------------------
module hazard_tag_pipe #(
    parameter int INST_W   = 16,
    parameter int REG_W    = 3,
    parameter int LINK_REG = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] issue_inst,
    input  logic              issue_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              freeze,
    output logic              regWrtD,
    output logic              regWrtX,
    output logic              regWrtM,
    output logic              regWrtW,
    output logic [REG_W-1:0]  wrtRegD,
    output logic [REG_W-1:0]  wrtRegX,
    output logic [REG_W-1:0]  wrtRegM,
    output logic [REG_W-1:0]  wrtRegW,
    output logic              branchInstD,
    output logic              branchInstX,
    output logic [2:0]        wr_pending_cnt
);

    localparam logic [REG_W-1:0] LINK = REG_W'(LINK_REG);

    // Write tag carried by every stage. The branch flag only matters in D and
    // X (it is resolved in X), so it is kept separately for those two stages.
    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] rd;
    } wtag_t;

    // Where the destination register of the decoded instruction comes from.
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_RD75,
        SRC_RD42,
        SRC_RD108,
        SRC_LINK
    } rdSrc_t;

    logic [4:0] opcode;
    rdSrc_t     rdSrc;
    logic       decBr;
    wtag_t      decTag;

    wtag_t stageD, stageX, stageM, stageW;
    logic  brD, brX;

    wtag_t nextD, nextX, nextM, nextW;
    logic  nextBrD, nextBrX;
    logic  insertBubble;
    logic [2:0] nextCnt;

    // Bits [1:0] never name a register in any format; they are deliberately
    // left out of the decode.
    logic unusedInstBits;
    assign unusedInstBits = ^issue_inst[1:0];

    assign opcode = issue_inst[15:11];

    // Opcode classification. Only the opcode picks the register field; the
    // field itself is extracted afterwards so a non-writer always carries rd=0.
    always_comb begin
        rdSrc = SRC_NONE;
        decBr = 1'b0;
        casez (opcode)
            5'b010??,
            5'b101??,
            5'b10001: rdSrc = SRC_RD75;
            5'b11011,
            5'b11010,
            5'b11001,
            5'b111??: rdSrc = SRC_RD42;
            5'b10011,
            5'b11000,
            5'b10010: rdSrc = SRC_RD108;
            5'b00110,
            5'b00111: begin
                rdSrc = SRC_LINK;
                decBr = 1'b1;
            end
            5'b00100,
            5'b00101,
            5'b011??: decBr = 1'b1;
            default:  rdSrc = SRC_NONE;
        endcase
    end

    // Turn the classification into the tag that enters D.
    always_comb begin
        decTag.wr = (rdSrc != SRC_NONE);
        decTag.rd = '0;
        case (rdSrc)
            SRC_RD75:  decTag.rd = issue_inst[7:5];
            SRC_RD42:  decTag.rd = issue_inst[4:2];
            SRC_RD108: decTag.rd = issue_inst[10:8];
            SRC_LINK:  decTag.rd = LINK;
            default:   decTag.rd = '0;
        endcase
    end

    // Next stage contents. Freeze wins over everything: the sources of flush
    // and stall hold those signals while frozen, so ignoring them here loses
    // nothing. Otherwise the pipe shifts and D takes either a bubble or the
    // freshly decoded tag. A flush only kills D; the branch resolving in X
    // keeps moving into M.
    always_comb begin
        insertBubble = flush | stall | ~issue_valid;
        nextD   = stageD;
        nextX   = stageX;
        nextM   = stageM;
        nextW   = stageW;
        nextBrD = brD;
        nextBrX = brX;
        if (!freeze) begin
            nextW   = stageM;
            nextM   = stageX;
            nextX   = stageD;
            nextBrX = brD;
            if (insertBubble) begin
                nextD   = '0;
                nextBrD = 1'b0;
            end else begin
                nextD   = decTag;
                nextBrD = decBr;
            end
        end
    end

    // The pending-write count is registered alongside the stages, so it is
    // computed from the next stage contents rather than the current ones.
    always_comb begin
        nextCnt = {2'b00, nextD.wr} + {2'b00, nextX.wr}
                + {2'b00, nextM.wr} + {2'b00, nextW.wr};
    end

    // Stage registers and the pending-write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stageD         <= '0;
            stageX         <= '0;
            stageM         <= '0;
            stageW         <= '0;
            brD            <= 1'b0;
            brX            <= 1'b0;
            wr_pending_cnt <= '0;
        end else begin
            stageD         <= nextD;
            stageX         <= nextX;
            stageM         <= nextM;
            stageW         <= nextW;
            brD            <= nextBrD;
            brX            <= nextBrX;
            wr_pending_cnt <= nextCnt;
        end
    end

    assign regWrtD     = stageD.wr;
    assign regWrtX     = stageX.wr;
    assign regWrtM     = stageM.wr;
    assign regWrtW     = stageW.wr;
    assign wrtRegD     = stageD.rd;
    assign wrtRegX     = stageX.rd;
    assign wrtRegM     = stageM.rd;
    assign wrtRegW     = stageW.rd;
    assign branchInstD = brD;
    assign branchInstX = brX;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// ---------------------------------------------------------------------------
// tb_hazard_tag_pipe
//
// Purpose:
//   Self-checking bench for hazard_tag_pipe. A behavioural model keeps the
//   four stage tags in plain arrays and decodes instructions straight from
//   the ISA opcode table; directed scenarios and a randomized run compare the
//   DUT outputs against it.
// ---------------------------------------------------------------------------
module tb_hazard_tag_pipe;

    logic        clk;
    logic        rst_n;
    logic [15:0] issue_inst;
    logic        issue_valid;
    logic        stall;
    logic        flush;
    logic        freeze;
    logic        regWrtD, regWrtX, regWrtM, regWrtW;
    logic [2:0]  wrtRegD, wrtRegX, wrtRegM, wrtRegW;
    logic        branchInstD, branchInstX;
    logic [2:0]  wr_pending_cnt;

    int checks;
    int failures;

    // Model state, index 0 = D, 1 = X, 2 = M, 3 = W.
    bit         mWr[4];
    logic [2:0] mRd[4];
    bit         mBr[4];

    wire [20:0] obsVec = {regWrtD, regWrtX, regWrtM, regWrtW,
                          wrtRegD, wrtRegX, wrtRegM, wrtRegW,
                          branchInstD, branchInstX, wr_pending_cnt};

    hazard_tag_pipe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_inst     (issue_inst),
        .issue_valid    (issue_valid),
        .stall          (stall),
        .flush          (flush),
        .freeze         (freeze),
        .regWrtD        (regWrtD),
        .regWrtX        (regWrtX),
        .regWrtM        (regWrtM),
        .regWrtW        (regWrtW),
        .wrtRegD        (wrtRegD),
        .wrtRegX        (wrtRegX),
        .wrtRegM        (wrtRegM),
        .wrtRegW        (wrtRegW),
        .branchInstD    (branchInstD),
        .branchInstX    (branchInstX),
        .wr_pending_cnt (wr_pending_cnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mkInst(input logic [4:0] op, input logic [10:0] rest);
        return {op, rest};
    endfunction

    // Reference decode written directly from the ISA opcode table.
    function automatic void modelDecode(input logic [15:0] inst, output bit wr,
                                        output logic [2:0] rd, output bit br);
        int op;
        op = int'(inst[15:11]);
        wr = 0;
        rd = 3'd0;
        br = 0;
        if (op == 6 || op == 7) begin
            wr = 1; rd = 3'd7; br = 1;
        end else if (op == 4 || op == 5 || (op >= 12 && op <= 15)) begin
            br = 1;
        end else if (op == 16 || op < 4) begin
            wr = 0;
        end else if (op == 18 || op == 19 || op == 24) begin
            wr = 1; rd = inst[10:8];
        end else if (op >= 25) begin
            wr = 1; rd = inst[4:2];
        end else begin
            wr = 1; rd = inst[7:5];
        end
    endfunction

    function automatic logic [20:0] expVec();
        int cnt;
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += int'(mWr[i]);
        return {mWr[0], mWr[1], mWr[2], mWr[3],
                mRd[0], mRd[1], mRd[2], mRd[3],
                mBr[0], mBr[1], 3'(cnt)};
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < 4; i++) begin
            mWr[i] = 0;
            mRd[i] = 3'd0;
            mBr[i] = 0;
        end
    endfunction

    // Drive one cycle of inputs, advance the model at the edge and return
    // 1 time unit after the edge so outputs can be sampled.
    task automatic applyStimulus(input logic [15:0] inst, input logic valid,
                                 input logic st, input logic fl, input logic fz);
        bit wr, br;
        logic [2:0] rd;
        issue_inst  = inst;
        issue_valid = valid;
        stall       = st;
        flush       = fl;
        freeze      = fz;
        @(posedge clk);
        if (!fz) begin
            for (int i = 3; i > 0; i--) begin
                mWr[i] = mWr[i-1];
                mRd[i] = mRd[i-1];
                mBr[i] = mBr[i-1];
            end
            if (fl || st || !valid) begin
                mWr[0] = 0; mRd[0] = 3'd0; mBr[0] = 0;
            end else begin
                modelDecode(inst, wr, rd, br);
                mWr[0] = wr; mRd[0] = rd; mBr[0] = br;
            end
        end
        #1;
    endtask

    task automatic drainPipe();
        for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [15:0] rtype;
        rst_n = 1'b0;
        issue_inst = 16'h0; issue_valid = 1'b0; stall = 1'b0; flush = 1'b0; freeze = 1'b0;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obsVec !== 21'd0) begin
            failures++;
            $display("[TB] FAIL reset_initial: got %h expected %h", obsVec, 21'd0);
        end
        rst_n = 1'b1;
        // Fill the pipe with four writers, then reset asynchronously mid-cycle.
        rtype = mkInst(5'b11011, 11'b01001110100);
        for (int i = 0; i < 4; i++) applyStimulus(rtype, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_pending_cnt !== 3'd4 || obsVec !== expVec()) begin
            failures++;
            $display("[TB] FAIL reset_fullpipe: got %h expected %h", obsVec, expVec());
        end
        #2;
        rst_n = 1'b0;
        modelClear();
        #1;
        checks++;
        if (obsVec !== 21'd0) begin
            failures++;
            $display("[TB] FAIL reset_async: got %h expected %h", obsVec, 21'd0);
        end
        #2;
        rst_n = 1'b1;
        applyStimulus(mkInst(5'b00110, 11'd0), 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obsVec !== expVec() || wrtRegD !== 3'd7) begin
            failures++;
            $display("[TB] FAIL reset_firstload: got %h expected %h", obsVec, expVec());
        end
    endtask

    task automatic test_rtype_latency();
        logic [2:0] expCnt[5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        logic [2:0] got;
        drainPipe();
        applyStimulus(mkInst(5'b11011, 11'b01001110100), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            got = (c == 0) ? wrtRegD : (c == 1) ? wrtRegX : (c == 2) ? wrtRegM
                : (c == 3) ? wrtRegW : 3'd5;
            checks++;
            if (got !== 3'd5 || wr_pending_cnt !== expCnt[c] || obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL rtype_cycle%0d: got rd=%0d cnt=%0d vec=%h expected rd=5 cnt=%0d vec=%h",
                         c, got, wr_pending_cnt, obsVec, expCnt[c], expVec());
            end
        end
    endtask

    task automatic test_jal();
        drainPipe();
        applyStimulus(mkInst(5'b00110, 11'b01001110100), 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (regWrtD !== 1'b1 || wrtRegD !== 3'd7 || branchInstD !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jal_decode: got wr=%b rd=%0d br=%b expected wr=1 rd=7 br=1",
                     regWrtD, wrtRegD, branchInstD);
        end
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (branchInstX !== 1'b1 || branchInstD !== 1'b0 || obsVec !== expVec()) begin
            failures++;
            $display("[TB] FAIL jal_toX: got %h expected %h", obsVec, expVec());
        end
    endtask

    task automatic test_st_beqz();
        drainPipe();
        applyStimulus(mkInst(5'b10000, 11'b01001110100), 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (regWrtD !== 1'b0 || wrtRegD !== 3'd0 || branchInstD !== 1'b0) begin
            failures++;
            $display("[TB] FAIL st_decode: got wr=%b rd=%0d br=%b expected wr=0 rd=0 br=0",
                     regWrtD, wrtRegD, branchInstD);
        end
        applyStimulus(mkInst(5'b01100, 11'b11111111111), 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (regWrtD !== 1'b0 || wrtRegD !== 3'd0 || branchInstD !== 1'b1) begin
            failures++;
            $display("[TB] FAIL beqz_decode: got wr=%b rd=%0d br=%b expected wr=0 rd=0 br=1",
                     regWrtD, wrtRegD, branchInstD);
        end
    endtask

    task automatic test_freeze();
        drainPipe();
        applyStimulus(mkInst(5'b10001, 11'b10101011100), 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wrtRegD !== 3'd2 || regWrtD !== 1'b1) begin
            failures++;
            $display("[TB] FAIL freeze_load: got rd=%0d wr=%b expected rd=2 wr=1", wrtRegD, regWrtD);
        end
        // Second frozen cycle also raises flush and stall, which must be ignored.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(mkInst(5'b11011, 11'b00000011100), 1'b1, c[0], c[0], 1'b1);
            checks++;
            if (wrtRegD !== 3'd2 || regWrtX !== 1'b0 || wr_pending_cnt !== 3'd1) begin
                failures++;
                $display("[TB] FAIL freeze_hold%0d: got rdD=%0d wrX=%b cnt=%0d expected rdD=2 wrX=0 cnt=1",
                         c, wrtRegD, regWrtX, wr_pending_cnt);
            end
        end
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wrtRegX !== 3'd2 || regWrtD !== 1'b0 || obsVec !== expVec()) begin
            failures++;
            $display("[TB] FAIL freeze_release: got %h expected %h", obsVec, expVec());
        end
    endtask

    task automatic test_flush();
        drainPipe();
        applyStimulus(mkInst(5'b01000, 11'b11000101000), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(mkInst(5'b10001, 11'b10101011100), 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (regWrtD !== 1'b0 || regWrtX !== 1'b1 || wrtRegX !== 3'd1 || wr_pending_cnt !== 3'd1) begin
            failures++;
            $display("[TB] FAIL flush_addi: got wrD=%b wrX=%b rdX=%0d cnt=%0d expected wrD=0 wrX=1 rdX=1 cnt=1",
                     regWrtD, regWrtX, wrtRegX, wr_pending_cnt);
        end
        // Flush and stall together, then an invalid issue: both give bubbles.
        applyStimulus(mkInst(5'b10001, 11'b10101011100), 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obsVec !== expVec() || regWrtD !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_stall: got %h expected %h", obsVec, expVec());
        end
        applyStimulus(mkInst(5'b10001, 11'b10101011100), 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obsVec !== expVec() || regWrtD !== 1'b0 || wr_pending_cnt !== 3'd1) begin
            failures++;
            $display("[TB] FAIL invalid_bubble: got %h expected %h", obsVec, expVec());
        end
    endtask

    task automatic test_back_to_back();
        drainPipe();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(mkInst(5'b01000 + 5'(c % 4), {3'b000, 3'(c), 5'b00000}),
                          1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obsVec !== expVec() || wr_pending_cnt !== 3'((c < 3) ? c + 1 : 4)) begin
                failures++;
                $display("[TB] FAIL back_to_back%0d: got %h expected %h", c, obsVec, expVec());
            end
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(16'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                          ($urandom_range(7) == 0), ($urandom_range(5) == 0));
            checks++;
            if (obsVec !== expVec()) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random_cycle%0d: got %h expected %h", c, obsVec, expVec());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_rtype_latency();
        test_jal();
        test_st_beqz();
        test_freeze();
        test_flush();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
